ddr_ring_buffer_burst_sched: RTL and testbench

- Burst scheduler for the DDR ring buffer. Shares a single datamover command port between S2MM (ififo→DDR) and MM2S (DDR→ofifo) bursts.
- Owns the ring buffer write/read pointers, DDR fill level, wrap handling, data-loss flag and end-of-buffer flag.
- Sits between the stage FIFOs and the AXI datamover.
- Exactly one command is outstanding at a time.

---
 rtl/ddr_ring_buffer_burst_sched.sv | 180 ++++++++++++++++++
 tb/tb_ddr_ring_buffer_burst_sched.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_ring_buffer_burst_sched.sv
`default_nettype none
// ============================================================================
// Module   : ddr_ring_buffer_burst_sched
// Purpose  : Shares one datamover command port between S2MM and MM2S bursts
//            and owns the DDR ring buffer pointers, fill level and flags.
// Option   : DDR_RB_SCHED_WR_PRIORITY_EN selects fixed write priority.
// Revision : 1.0 - initial release
// ============================================================================
module ddr_ring_buffer_burst_sched #(
   parameter int AXI_ADDR_WIDTH    = 32,
   parameter int AXI_DATA_WIDTH    = 32,
   parameter int STAGE_FIFOS_DEPTH = 256,
   parameter int BURST_BEATS       = 16
) (
   input  logic                                              clk,
   input  logic                                              rst,
   input  logic                                              soft_rstn,
   input  logic [AXI_ADDR_WIDTH-1:0]                         axi_base_addr,
   input  logic [31:0]                                       ring_buffer_len,
   input  logic [$clog2(STAGE_FIFOS_DEPTH):0]                ififo_fill,
   input  logic                                              ififo_full,
   input  logic [$clog2(STAGE_FIFOS_DEPTH):0]                ofifo_fill,
   output logic                                              cmd_valid,
   input  logic                                              cmd_ready,
   output logic                                              cmd_write,
   output logic [AXI_ADDR_WIDTH-1:0]                         cmd_addr,
   input  logic                                              cmd_done,
   output logic [AXI_ADDR_WIDTH-1:0]                         ring_buffer_wptr,
   output logic [AXI_ADDR_WIDTH-1:0]                         ring_buffer_rptr,
   output logic [AXI_ADDR_WIDTH-$clog2(AXI_DATA_WIDTH/8):0]  core_fill,
   output logic                                              empty,
   output logic                                              data_loss,
   output logic                                              ddr_eob,
   input  logic                                              clear_eob
);

   localparam int c_BEAT_BYTES  = AXI_DATA_WIDTH / 8;
   localparam int c_BEAT_SHIFT  = $clog2(c_BEAT_BYTES);
   localparam int c_BURST_BYTES = BURST_BEATS * c_BEAT_BYTES;
   localparam int c_CFW         = AXI_ADDR_WIDTH - c_BEAT_SHIFT + 1;
   localparam int c_XW          = ((AXI_ADDR_WIDTH > 32) ? AXI_ADDR_WIDTH : 32) + 2;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CMD  = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   state_t                    r_state;
   logic                      r_cmd_valid;
   logic                      r_cmd_write;
   logic [AXI_ADDR_WIDTH-1:0] r_cmd_addr;
   logic [AXI_ADDR_WIDTH-1:0] r_wptr;
   logic [AXI_ADDR_WIDTH-1:0] r_rptr;
   logic [c_CFW-1:0]          r_core_fill;
   logic                      r_data_loss;
   logic                      r_ddr_eob;
   logic                      r_srst_pend;

   logic [c_XW-1:0]           w_len_beats;
   logic [c_XW-1:0]           w_fill_plus;
   logic [c_XW-1:0]           w_wptr_inc;
   logic [c_XW-1:0]           w_rptr_inc;
   logic                      w_wr_ok;
   logic                      w_rd_ok;
   logic                      w_grant;
   logic                      w_grant_wr;
   logic                      w_overflow;
   logic                      w_done;
   logic                      w_soft_clr;
   logic                      w_apply_wr;
   logic                      w_apply_rd;
   logic                      w_wptr_wrap;
   logic                      w_rptr_wrap;

   // All capacity arithmetic is done in a widened domain so sums never overflow.
   assign w_len_beats = c_XW'(ring_buffer_len >> c_BEAT_SHIFT);
   assign w_fill_plus = c_XW'(r_core_fill) + c_XW'(BURST_BEATS);
   assign w_wr_ok     = (c_XW'(ififo_fill) >= c_XW'(BURST_BEATS)) && (w_fill_plus <= w_len_beats);
   assign w_rd_ok     = (c_XW'(r_core_fill) >= c_XW'(BURST_BEATS)) &&
                        ((c_XW'(ofifo_fill) + c_XW'(BURST_BEATS)) <= c_XW'(STAGE_FIFOS_DEPTH));
   assign w_overflow  = ififo_full && (w_fill_plus > w_len_beats);

   assign w_wptr_inc  = c_XW'(r_wptr) + c_XW'(c_BURST_BYTES);
   assign w_rptr_inc  = c_XW'(r_rptr) + c_XW'(c_BURST_BYTES);
   assign w_wptr_wrap = (w_wptr_inc == c_XW'(ring_buffer_len));
   assign w_rptr_wrap = (w_rptr_inc == c_XW'(ring_buffer_len));

`ifdef DDR_RB_SCHED_WR_PRIORITY_EN
   assign w_grant_wr = w_wr_ok;
`else
   logic r_last_wr;
   assign w_grant_wr = w_wr_ok && (!w_rd_ok || !r_last_wr);
`endif
   assign w_grant    = (w_wr_ok || w_rd_ok) && soft_rstn;

   // A soft reset seen mid-burst is deferred until the burst retires.
   assign w_done     = (r_state == S_WAIT) && cmd_done;
   assign w_soft_clr = ((r_state == S_IDLE) && !soft_rstn) ||
                       (w_done && (r_srst_pend || !soft_rstn));
   assign w_apply_wr = w_done && !w_soft_clr && r_cmd_write;
   assign w_apply_rd = w_done && !w_soft_clr && !r_cmd_write;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cmd_valid <= 1'b0;
         r_cmd_write <= 1'b0;
         r_cmd_addr  <= '0;
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_core_fill <= '0;
         r_data_loss <= 1'b0;
         r_ddr_eob   <= 1'b0;
         r_srst_pend <= 1'b0;
`ifndef DDR_RB_SCHED_WR_PRIORITY_EN
         r_last_wr   <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_grant) begin
                  r_cmd_valid <= 1'b1;
                  r_cmd_write <= w_grant_wr;
                  r_cmd_addr  <= axi_base_addr + (w_grant_wr ? r_wptr : r_rptr);
                  r_state     <= S_CMD;
`ifndef DDR_RB_SCHED_WR_PRIORITY_EN
                  r_last_wr   <= w_grant_wr;
`endif
               end
            end
            S_CMD: begin
               if (!soft_rstn) r_srst_pend <= 1'b1;
               if (cmd_ready) begin
                  r_cmd_valid <= 1'b0;
                  r_state     <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (cmd_done) begin
                  r_state     <= S_IDLE;
                  r_srst_pend <= 1'b0;
               end else if (!soft_rstn) begin
                  r_srst_pend <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase

         if (w_soft_clr) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_core_fill <= '0;
         end else if (w_apply_wr) begin
            r_wptr      <= w_wptr_wrap ? '0 : w_wptr_inc[AXI_ADDR_WIDTH-1:0];
            r_core_fill <= r_core_fill + c_CFW'(BURST_BEATS);
         end else if (w_apply_rd) begin
            r_rptr      <= w_rptr_wrap ? '0 : w_rptr_inc[AXI_ADDR_WIDTH-1:0];
            r_core_fill <= r_core_fill - c_CFW'(BURST_BEATS);
         end

         r_data_loss <= w_soft_clr ? 1'b0 : (r_data_loss | w_overflow);

         if (clear_eob || w_soft_clr)        r_ddr_eob <= 1'b0;
         else if (w_apply_wr && w_wptr_wrap) r_ddr_eob <= 1'b1;
      end
   end

   assign cmd_valid        = r_cmd_valid;
   assign cmd_write        = r_cmd_write;
   assign cmd_addr         = r_cmd_addr;
   assign ring_buffer_wptr = r_wptr;
   assign ring_buffer_rptr = r_rptr;
   assign core_fill        = r_core_fill;
   assign empty            = (r_core_fill == '0);
   assign data_loss        = r_data_loss;
   assign ddr_eob          = r_ddr_eob;

endmodule
`default_nettype wire

// File: tb/tb_ddr_ring_buffer_burst_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr_ring_buffer_burst_sched
// Purpose  : Directed bench with a transaction-level ring model compared
//            every cycle, plus hand-computed literal checkpoints.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ddr_ring_buffer_burst_sched;

   localparam int c_BURST = 16;
   localparam int c_BB    = 64;
   localparam int c_DEPTH = 256;

   logic        clk = 1'b0;
   logic        rst, soft_rstn, ififo_full, cmd_ready, cmd_done, clear_eob;
   logic [31:0] axi_base_addr, ring_buffer_len;
   logic [8:0]  ififo_fill, ofifo_fill;
   logic        cmd_valid, cmd_write, empty, data_loss, ddr_eob;
   logic [31:0] cmd_addr, ring_buffer_wptr, ring_buffer_rptr;
   logic [30:0] core_fill;

   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   ddr_ring_buffer_burst_sched dut (
      .clk(clk), .rst(rst), .soft_rstn(soft_rstn),
      .axi_base_addr(axi_base_addr), .ring_buffer_len(ring_buffer_len),
      .ififo_fill(ififo_fill), .ififo_full(ififo_full), .ofifo_fill(ofifo_fill),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_done(cmd_done),
      .ring_buffer_wptr(ring_buffer_wptr), .ring_buffer_rptr(ring_buffer_rptr),
      .core_fill(core_fill), .empty(empty), .data_loss(data_loss),
      .ddr_eob(ddr_eob), .clear_eob(clear_eob)
   );

   task automatic chk(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Ring model: phase 0 = no command, 1 = command offered, 2 = burst in flight.
   int          m_phase, m_w, m_r, m_fill;
   bit          m_valid, m_write, m_dl, m_eob, m_last_w, m_pend;
   logic [31:0] m_addr;
   int          lenb;
   bit          wr_ok, rd_ok, gw, sclr, wrap, dl_set;

   always @(posedge clk) begin
      if (rst) begin
         m_phase = 0; m_valid = 0; m_write = 0; m_addr = '0;
         m_w = 0; m_r = 0; m_fill = 0; m_dl = 0; m_eob = 0;
         m_last_w = 0; m_pend = 0;
      end else begin
         lenb   = int'(ring_buffer_len) / 4;
         dl_set = ififo_full && (m_fill + c_BURST > lenb);
         sclr   = 0;
         wrap   = 0;
         if (m_phase == 0) begin
            if (!soft_rstn) sclr = 1;
            else begin
               wr_ok = (int'(ififo_fill) >= c_BURST) && (m_fill + c_BURST <= lenb);
               rd_ok = (m_fill >= c_BURST) && (c_DEPTH - int'(ofifo_fill) >= c_BURST);
`ifdef DDR_RB_SCHED_WR_PRIORITY_EN
               gw = wr_ok;
`else
               gw = wr_ok && !(rd_ok && m_last_w);
`endif
               if (wr_ok || rd_ok) begin
                  m_valid  = 1;
                  m_write  = gw;
                  m_addr   = axi_base_addr + 32'(gw ? m_w : m_r);
                  m_phase  = 1;
                  m_last_w = gw;
               end
            end
         end else if (m_phase == 1) begin
            if (!soft_rstn) m_pend = 1;
            if (cmd_ready) begin m_valid = 0; m_phase = 2; end
         end else begin
            if (cmd_done) begin
               if (m_pend || !soft_rstn) sclr = 1;
               else if (m_write) begin
                  m_w    = (m_w + c_BB) % int'(ring_buffer_len);
                  wrap   = (m_w == 0);
                  m_fill = m_fill + c_BURST;
               end else begin
                  m_r    = (m_r + c_BB) % int'(ring_buffer_len);
                  m_fill = m_fill - c_BURST;
               end
               m_phase = 0;
               m_pend  = 0;
            end else if (!soft_rstn) m_pend = 1;
         end
         if (sclr) begin m_w = 0; m_r = 0; m_fill = 0; end
         m_dl = sclr ? 1'b0 : (m_dl | dl_set);
         if (clear_eob || sclr) m_eob = 0;
         else if (wrap)         m_eob = 1;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_cmd_valid", cmd_valid, m_valid);
         chk("m_cmd_write", cmd_write, m_write);
         chk("m_cmd_addr",  cmd_addr,  m_addr);
         chk("m_wptr",      ring_buffer_wptr, m_w);
         chk("m_rptr",      ring_buffer_rptr, m_r);
         chk("m_core_fill", core_fill, m_fill);
         chk("m_empty",     empty, (m_fill == 0));
         chk("m_data_loss", data_loss, m_dl);
         chk("m_ddr_eob",   ddr_eob, m_eob);
      end
   end

   task automatic wait_valid(output bit ok);
      int n = 0;
      while (!cmd_valid && n < 64) begin @(negedge clk); n++; end
      ok = cmd_valid;
      if (!ok) chk("issue_timeout", 0, 1);
   endtask

   // Serves one command: optional ready stall, optional soft reset in WAIT,
   // done pulse three cycles after the handshake. Returns in IDLE.
   task automatic run_burst(input bit exp_w, input logic [31:0] exp_addr,
                            input int ready_delay, input bit srst);
      bit ok;
      wait_valid(ok);
      if (!ok) return;
      chk("lit_cmd_write", cmd_write, exp_w);
      chk("lit_cmd_addr",  cmd_addr,  exp_addr);
      for (int i = 0; i < ready_delay; i++) begin
         @(negedge clk);
         chk("stall_valid", cmd_valid, 1);
         chk("stall_addr",  cmd_addr,  exp_addr);
      end
      cmd_ready = 1'b1;
      @(negedge clk);
      if (srst) soft_rstn = 1'b0;
      @(negedge clk);
      @(negedge clk);
      cmd_done = 1'b1;
      @(negedge clk);
      cmd_done = 1'b0;
   endtask

   localparam logic [31:0] c_BASE = 32'h8000_0000;
   bit ok;

   initial begin
      rst = 1; soft_rstn = 1; axi_base_addr = c_BASE; ring_buffer_len = 32'd1024;
      ififo_fill = 0; ififo_full = 0; ofifo_fill = 9'd256;
      cmd_ready = 1; cmd_done = 0; clear_eob = 0;
      repeat (3) @(negedge clk);
      chk_en = 1;
      chk("rst_valid", cmd_valid, 0);
      chk("rst_addr",  cmd_addr, 0);
      chk("rst_empty", empty, 1);
      rst = 0;
      ififo_fill = 9'd16;

      // first write burst lands at base+0
      run_burst(1, c_BASE, 0, 0);
      chk("w1_wptr", ring_buffer_wptr, 64);
      chk("w1_fill", core_fill, 16);
      chk("w1_empty", empty, 0);

      for (int i = 1; i < 16; i++) run_burst(1, c_BASE + 32'(64 * i), 0, 0);
      chk("w16_wptr", ring_buffer_wptr, 0);
      chk("w16_eob",  ddr_eob, 1);
      chk("w16_fill", core_fill, 256);
      clear_eob = 1;
      @(negedge clk);
      clear_eob = 0;
      chk("eob_clr", ddr_eob, 0);

      // overflow while the ring is full
      ififo_fill = 9'd256; ififo_full = 1;
      @(negedge clk);
      chk("dl_set", data_loss, 1);
      repeat (3) begin @(negedge clk); chk("dl_no_issue", cmd_valid, 0); end
      ififo_full = 0;
      @(negedge clk);
      chk("dl_sticky", data_loss, 1);

      // drain to 32 beats, then both sides eligible
      ififo_fill = 0; ofifo_fill = 0;
      for (int i = 0; i < 14; i++) run_burst(0, c_BASE + 32'(64 * i), 0, 0);
      chk("drain_fill", core_fill, 32);
      ififo_fill = 9'd16;
`ifdef DDR_RB_SCHED_WR_PRIORITY_EN
      run_burst(1, c_BASE + 32'd0,   0, 0);
      run_burst(1, c_BASE + 32'd64,  0, 0);
      run_burst(1, c_BASE + 32'd128, 0, 0);
      run_burst(1, c_BASE + 32'd192, 0, 0);
`else
      run_burst(1, c_BASE + 32'd0,   0, 0);
      run_burst(0, c_BASE + 32'd896, 0, 0);
      run_burst(1, c_BASE + 32'd64,  0, 0);
      run_burst(0, c_BASE + 32'd960, 0, 0);
      chk("rr_rptr_wrap", ring_buffer_rptr, 0);
`endif
      ififo_fill = 0; ofifo_fill = 9'd256;

      // ready stall, then soft reset during WAIT
      cmd_ready = 0;
      ififo_fill = 9'd16;
`ifdef DDR_RB_SCHED_WR_PRIORITY_EN
      run_burst(1, c_BASE + 32'd256, 5, 1);
`else
      run_burst(1, c_BASE + 32'd128, 5, 1);
`endif
      chk("srst_wptr", ring_buffer_wptr, 0);
      chk("srst_rptr", ring_buffer_rptr, 0);
      chk("srst_fill", core_fill, 0);
      @(negedge clk);
      chk("srst_no_issue", cmd_valid, 0);
      soft_rstn = 1;

      // hard reset during WAIT, then a stray done
      run_burst(1, c_BASE, 0, 0);
      wait_valid(ok);
      if (ok) chk("w2_addr", cmd_addr, c_BASE + 32'd64);
      @(negedge clk);
      rst = 1; ififo_fill = 0;
      @(negedge clk);
      chk("hr_valid", cmd_valid, 0);
      chk("hr_write", cmd_write, 0);
      chk("hr_addr",  cmd_addr, 0);
      chk("hr_wptr",  ring_buffer_wptr, 0);
      chk("hr_fill",  core_fill, 0);
      chk("hr_empty", empty, 1);
      rst = 0;
      @(negedge clk);
      cmd_done = 1;
      @(negedge clk);
      cmd_done = 0;
      @(negedge clk);
      chk("stray_wptr",  ring_buffer_wptr, 0);
      chk("stray_fill",  core_fill, 0);
      chk("stray_valid", cmd_valid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
